fp_atan_arb: RTL and testbench

- Shares one fp_atan_lut pipeline among NREQ requesters.
- Arbitration is round-robin, gated by credits.
- Issue is registered. An owner-tag pipeline aligned to the unit latency routes each result to a per-requester response FIFO.
- Sits between the vector/scalar FP issue logic and the single atan LUT instance.

---
 rtl/fp_atan_arb_pkg.sv | 21 ++
 rtl/fp_atan_rsp_fifo.sv | 51 +++++
 rtl/fp_atan_arb.sv | 176 +++++++++++++++++
 tb/tb_fp_atan_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_atan_arb_pkg.sv
// Shared types and constants for the atan LUT arbiter.
// Optional grant statistics are enabled with FP_ATAN_ARB_STATS_EN.
package fp_atan_arb_pkg;

  localparam int unsigned DEF_LATENCY = 2;
  localparam int unsigned TAG_ID_W    = 3;

  localparam logic [31:0] ATAN_ONE  = 32'h3F490FDB;
  localparam logic [31:0] ATAN_MONE = 32'hBF490FDB;

  // Owner tag; id is sized for the largest supported NREQ (8).
  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp_atan_rsp_fifo.sv
// Per-requester 32-bit response FIFO; data output reads zero while empty.
module fp_atan_rsp_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [31:0]                  din,
  input  logic                         pop,
  output logic [31:0]                  dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rd];
  assign w_do_pop  = pop & ~empty;
  // A pop frees the slot, so a full FIFO may accept a push in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fp_atan_arb.sv
// Credit-gated round-robin sharing of one atan LUT among NREQ requesters.
// Define FP_ATAN_ARB_STATS_EN to add per-requester grant counters.
module fp_atan_arb
  import fp_atan_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned LATENCY   = DEF_LATENCY,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  input  logic [NREQ*32-1:0]     req_data,
  output logic [NREQ-1:0]        req_rdy,
  output logic [NREQ-1:0]        rsp_vld,
  output logic [NREQ*32-1:0]     rsp_data,
  input  logic [NREQ-1:0]        rsp_rdy,
  output logic                   atan_do,
  output logic [31:0]            atan_ain,
  output logic                   atan_en,
  input  logic [31:0]            atan_out,
  input  logic                   atan_vld,
  output logic                   busy,
  output logic                   err
`ifdef FP_ATAN_ARB_STATS_EN
  ,
  input  logic [id_w(NREQ)-1:0]  stat_sel,
  output logic [31:0]            stat_cnt
`endif
);

  localparam int unsigned ID_W = id_w(NREQ);
  localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
  localparam int unsigned BW   = $clog2(LATENCY + 2);

  logic [ID_W-1:0] r_ptr;
  logic [CW-1:0]   r_credit [NREQ];
  logic            r_do;
  logic [31:0]     r_ain;
  tag_t            r_iss_tag;
  tag_t            r_tag [LATENCY];
  logic [BW-1:0]   r_blank;
  logic            r_err;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_pop;
  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_full;
  logic [NREQ-1:0] w_empty;
  logic [CW-1:0]   w_count [NREQ];
  logic [ID_W-1:0] w_win;
  logic            w_any;
  logic            w_ovf;
  logic            w_mis;
  logic            w_busy;
  tag_t            w_head;

  assign w_head   = r_tag[LATENCY-1];
  assign req_rdy  = w_gnt;
  assign rsp_vld  = ~w_empty;
  assign w_pop    = rsp_vld & rsp_rdy;
  assign atan_do  = r_do;
  assign atan_ain = r_ain;
  assign atan_en  = 1'b1;
  assign err      = r_err;
  assign busy     = w_busy;
  // Results outside the post-reset blanking window must match the owner pipe.
  assign w_mis    = (r_blank == '0) && (atan_vld ^ w_head.v);

  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_vld[i] && (r_credit[i] != '0) && !rst;
    end
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_any && w_elig[(int'(r_ptr) + k) % NREQ]) begin
        w_any = 1'b1;
        w_win = ID_W'((int'(r_ptr) + k) % NREQ);
      end
    end
    w_gnt[w_win] = w_any;
  end

  always_comb begin
    w_push = '0;
    w_ovf  = 1'b0;
    w_busy = r_iss_tag.v;
    for (int i = 0; i < NREQ; i++) begin
      if (atan_vld && w_head.v && (w_head.id == TAG_ID_W'(i))) begin
        w_push[i] = !w_full[i] || w_pop[i];
        w_ovf     = w_full[i] && !w_pop[i];
      end
      w_busy = w_busy | (w_count[i] != '0);
    end
    for (int k = 0; k < LATENCY; k++) begin
      w_busy = w_busy | r_tag[k].v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= ID_W'(NREQ - 1);
      r_do      <= 1'b0;
      r_ain     <= '0;
      r_iss_tag <= '0;
      r_blank   <= BW'(LATENCY + 1);
      r_err     <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        r_credit[i] <= CW'(RSP_DEPTH);
      end
      for (int k = 0; k < LATENCY; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_do      <= w_any;
      r_iss_tag <= '{v: w_any, id: TAG_ID_W'(w_win)};
      if (w_any) begin
        r_ptr <= w_win;
        r_ain <= req_data[32*w_win +: 32];
      end
      r_tag[0] <= r_iss_tag;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        r_credit[i] <= r_credit[i] - CW'(w_gnt[i]) + CW'(w_pop[i]);
      end
      if (r_blank != '0) begin
        r_blank <= r_blank - BW'(1);
      end
      if (w_mis || w_ovf) begin
        r_err <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
    fp_atan_rsp_fifo #(
      .DEPTH(RSP_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (w_push[gi]),
      .din  (atan_out),
      .pop  (w_pop[gi]),
      .dout (rsp_data[32*gi +: 32]),
      .full (w_full[gi]),
      .empty(w_empty[gi]),
      .count(w_count[gi])
    );
  end

`ifdef FP_ATAN_ARB_STATS_EN
  logic [31:0] r_cnt [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i]) begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
      stat_cnt <= (int'(stat_sel) < NREQ) ? r_cnt[stat_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_atan_arb.sv
// Directed bench for fp_atan_arb with a two-cycle behavioural atan unit.
module tb_fp_atan_arb;
  import fp_atan_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned DEP  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_vld = '0;
  logic [NREQ*32-1:0] req_data = '0;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ-1:0]   rsp_vld;
  logic [NREQ*32-1:0] rsp_data;
  logic [NREQ-1:0]   rsp_rdy = '0;
  logic              atan_do;
  logic [31:0]       atan_ain;
  logic              atan_en;
  logic [31:0]       atan_out;
  logic              atan_vld;
  logic              busy;
  logic              err;
`ifdef FP_ATAN_ARB_STATS_EN
  logic [1:0]        stat_sel = '0;
  logic [31:0]       stat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_atan_arb #(
    .NREQ     (NREQ),
    .LATENCY  (LAT),
    .RSP_DEPTH(DEP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_data(req_data),
    .req_rdy (req_rdy),
    .rsp_vld (rsp_vld),
    .rsp_data(rsp_data),
    .rsp_rdy (rsp_rdy),
    .atan_do (atan_do),
    .atan_ain(atan_ain),
    .atan_en (atan_en),
    .atan_out(atan_out),
    .atan_vld(atan_vld),
    .busy    (busy),
    .err     (err)
`ifdef FP_ATAN_ARB_STATS_EN
    ,
    .stat_sel(stat_sel),
    .stat_cnt(stat_cnt)
`endif
  );

  // Behavioural unit: not reset, so it keeps emitting stale results across rst.
  function automatic logic [31:0] model_atan(input logic [31:0] x);
    if (x == 32'h3F800000) return ATAN_ONE;
    if (x == 32'hBF800000) return ATAN_MONE;
    return x ^ 32'h5A5A5A5A;
  endfunction

  logic        m_v0 = 1'b0;
  logic        m_v1 = 1'b0;
  logic [31:0] m_d0 = '0;
  logic [31:0] m_d1 = '0;
  logic        m_force = 1'b0;

  always @(posedge clk) begin
    m_v0 <= atan_do;
    m_v1 <= m_v0;
    m_d0 <= model_atan(atan_ain);
    m_d1 <= m_d0;
  end

  assign atan_vld = m_v1 | m_force;
  assign atan_out = m_d1;

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    req_vld = '0;
    rsp_rdy = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    req_vld  = '1;
    req_data = {4{32'h3F800000}};
    #1;
    if (req_rdy !== 4'b0000) begin
      bad++; $display("FAIL reset_rdy got=%b exp=0000", req_rdy);
    end
    total++;
    @(negedge clk);
    req_vld = '0;
    #1;
    if (rsp_vld !== 4'b0000) begin
      bad++; $display("FAIL reset_rsp_vld got=%b exp=0000", rsp_vld);
    end
    total++;
    if (rsp_data !== '0) begin
      bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data);
    end
    total++;
    if (atan_do !== 1'b0 || atan_ain !== 32'h0) begin
      bad++; $display("FAIL reset_issue got=%b/%h exp=0/0", atan_do, atan_ain);
    end
    total++;
    if (atan_en !== 1'b1) begin
      bad++; $display("FAIL reset_en got=%b exp=1", atan_en);
    end
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_busy_err got=%b/%b exp=0/0", busy, err);
    end
    total++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_data = '0;
    req_data[31:0] = 32'h3F800000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_vld = (c == 0) ? 4'b0001 : 4'b0000;
      rsp_rdy = (c == 4) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0 && req_rdy !== 4'b0001) begin
        bad++; $display("FAIL single_grant got=%b exp=0001", req_rdy);
      end
      if (c == 1 && (atan_do !== 1'b1 || atan_ain !== 32'h3F800000 || busy !== 1'b1)) begin
        bad++; $display("FAIL single_issue got=%b/%h/%b exp=1/3f800000/1", atan_do, atan_ain, busy);
      end
      if (c >= 1 && c <= 3 && rsp_vld !== 4'b0000) begin
        bad++; $display("FAIL single_early c=%0d got=%b exp=0000", c, rsp_vld);
      end
      if (c == 2 && atan_do !== 1'b0) begin
        bad++; $display("FAIL single_do_drop got=%b exp=0", atan_do);
      end
      if (c == 3 && atan_vld !== 1'b1) begin
        bad++; $display("FAIL single_unit_vld got=%b exp=1", atan_vld);
      end
      if (c == 4 && (rsp_vld !== 4'b0001 || rsp_data[31:0] !== ATAN_ONE)) begin
        bad++; $display("FAIL single_rsp got=%b/%h exp=0001/%h", rsp_vld, rsp_data[31:0], ATAN_ONE);
      end
      if (c == 5 && (rsp_vld !== 4'b0000 || busy !== 1'b0 || err !== 1'b0)) begin
        bad++; $display("FAIL single_done got=%b/%b/%b exp=0000/0/0", rsp_vld, busy, err);
      end
      total++;
    end
  endtask

  task automatic test_round_robin();
    int got = 0;
    do_reset();
    req_data = {4{32'h3F800000}};
    rsp_rdy  = '1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      req_vld = (k < 12) ? 4'b1111 : 4'b0000;
      #1;
      got += $countones(rsp_vld);
      if (k < 12) begin
        if (req_rdy !== 4'(1 << (k % 4))) begin
          bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_rdy, 4'(1 << (k % 4)));
        end
        total++;
      end
      if (k >= 1 && k <= 12) begin
        if (atan_do !== 1'b1) begin
          bad++; $display("FAIL rr_issue k=%0d got=%b exp=1", k, atan_do);
        end
        total++;
      end
      if (k >= 4 && k < 16) begin
        if (rsp_vld !== 4'(1 << ((k - 4) % 4)) ||
            rsp_data[32*((k-4)%4) +: 32] !== ATAN_ONE) begin
          bad++; $display("FAIL rr_rsp k=%0d got=%b/%h exp=%b/%h", k, rsp_vld,
                          rsp_data[32*((k-4)%4) +: 32], 4'(1 << ((k - 4) % 4)), ATAN_ONE);
        end
        total++;
      end
    end
    if (got != 12 || err !== 1'b0) begin
      bad++; $display("FAIL rr_count got=%0d/%b exp=12/0", got, err);
    end
    total++;
  endtask

  task automatic test_backpressure();
    logic [3:0] seq [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                             4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001,
                             4'b0010, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] tail [4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000};
    do_reset();
    req_data = {4{32'h3F800000}};
    rsp_rdy  = 4'b1011;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req_vld = 4'b1111;
      #1;
      if (req_rdy !== seq[k]) begin
        bad++; $display("FAIL bp_grant k=%0d got=%b exp=%b", k, req_rdy, seq[k]);
      end
      total++;
    end
    if (rsp_vld[2] !== 1'b1) begin
      bad++; $display("FAIL bp_held got=%b exp=1", rsp_vld[2]);
    end
    total++;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      req_vld = 4'b0100;
      rsp_rdy = 4'b1111;
      #1;
      if (req_rdy !== tail[m]) begin
        bad++; $display("FAIL bp_restore m=%0d got=%b exp=%b", m, req_rdy, tail[m]);
      end
      total++;
    end
    req_vld = '0;
  endtask

  task automatic test_routing();
    logic [3:0] seq [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    int n1 = 0;
    int n3 = 0;
    do_reset();
    req_data = '0;
    req_data[63:32]  = 32'hBF800000;
    req_data[127:96] = 32'h3F800000;
    rsp_rdy = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_vld = (k < 4) ? 4'b1010 : 4'b0000;
      #1;
      if (k < 4) begin
        if (req_rdy !== seq[k]) begin
          bad++; $display("FAIL route_grant k=%0d got=%b exp=%b", k, req_rdy, seq[k]);
        end
        total++;
      end
      if (rsp_vld[1]) begin
        n1++;
        if (rsp_data[63:32] !== ATAN_MONE) begin
          bad++; $display("FAIL route_r1 got=%h exp=%h", rsp_data[63:32], ATAN_MONE);
        end
        total++;
      end
      if (rsp_vld[3]) begin
        n3++;
        if (rsp_data[127:96] !== ATAN_ONE) begin
          bad++; $display("FAIL route_r3 got=%h exp=%h", rsp_data[127:96], ATAN_ONE);
        end
        total++;
      end
      if (rsp_vld[0] || rsp_vld[2]) begin
        bad++; $display("FAIL route_stray got=%b exp=x0x0", rsp_vld);
        total++;
      end
    end
    if (n1 != 2 || n3 != 2 || err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL route_count got=%0d/%0d/%b/%b exp=2/2/0/0", n1, n3, err, busy);
    end
    total++;
  endtask

  task automatic test_reset_midflight();
    logic [3:0] seq [5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    req_data = {4{32'h3F800000}};
    @(negedge clk);
    req_vld = 4'b0001;
    @(negedge clk);
    req_vld = 4'b0010;
    @(negedge clk);
    req_vld = 4'b0000;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL midrst_busy got=%b exp=0", busy);
    end
    total++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (rsp_vld !== 4'b0000 || err !== 1'b0) begin
        bad++; $display("FAIL midrst_quiet k=%0d got=%b/%b exp=0000/0", k, rsp_vld, err);
      end
      total++;
    end
    rsp_rdy = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_vld = 4'b0001;
      #1;
      if (req_rdy !== seq[k]) begin
        bad++; $display("FAIL midrst_credit k=%0d got=%b exp=%b", k, req_rdy, seq[k]);
      end
      total++;
    end
    req_vld = '0;
  endtask

  task automatic test_mismatch();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      m_force = (k == 9);
      #1;
      if (k <= 9 && err !== 1'b0) begin
        bad++; $display("FAIL mis_early k=%0d got=%b exp=0", k, err);
      end
      if (k >= 10 && err !== 1'b1) begin
        bad++; $display("FAIL mis_sticky k=%0d got=%b exp=1", k, err);
      end
      total++;
    end
    m_force = 1'b0;
    do_reset();
    #1;
    if (err !== 1'b0) begin
      bad++; $display("FAIL mis_clear got=%b exp=0", err);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_routing();
    test_reset_midflight();
    test_mismatch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
